// File: rtl/image_resize_avg_simple.sv
`default_nettype none
// ============================================================================
// Module   : image_resize_avg_simple
// Captures a 640x480 frame, averages 20x15 blocks to 32x32, streams to UART.
// Revision : 1.0
// ============================================================================
module image_resize_avg_simple (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        KEY_2,
  input  logic [7:0]  Read_DATA2,
  input  logic        tx_done,
  output logic        start_resize,
  output logic [22:0] read_addr_resize,
  output logic        done,
  output logic [7:0]  uart_tx,
  output logic        uart_trmt,
  output logic        avg_done,
  output logic        triggered
);

  localparam logic [1:0]  c_IDLE      = 2'd0;
  localparam logic [1:0]  c_READ      = 2'd1;
  localparam logic [1:0]  c_SEND      = 2'd2;
  localparam logic [1:0]  c_WAIT_TX   = 2'd3;
  localparam logic [22:0] c_LAST_ADDR = 23'd307199;
  localparam logic [9:0]  c_LAST_BYTE = 10'd1023;

  logic [1:0]  r_state;
  logic        r_key_prev;
  logic        w_start;

  // Read-side raster position, kept in step with read_addr_resize
  logic [9:0]  r_rd_x;
  logic [8:0]  r_rd_y;
  logic [4:0]  r_rd_bx;
  logic [4:0]  r_rd_sx;
  logic [4:0]  r_rd_by;
  logic [3:0]  r_rd_sy;

  // Position of the pixel whose data arrives on Read_DATA2 this cycle
  logic        r_v1;
  logic [9:0]  r_x1;
  logic [8:0]  r_y1;
  logic [4:0]  r_bx1;
  logic [4:0]  r_by1;
  logic        r_eob1;

  logic        r_flush;
  logic [4:0]  r_flush_by;
  logic        r_rows_done;
  logic [16:0] r_acc [0:31];
  logic [7:0]  w_quot [0:31];
  logic [9:0]  r_byte_idx;

  logic [7:0]  receive [0:479][0:639];
  logic [7:0]  out [0:31][0:31];

  assign w_start = !KEY_2 && r_key_prev;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_div
      assign w_quot[gi] = 8'(r_acc[gi] / 17'd300);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= c_IDLE;
      r_key_prev       <= 1'b1;
      start_resize     <= 1'b0;
      read_addr_resize <= '0;
      done             <= 1'b0;
      uart_tx          <= '0;
      uart_trmt        <= 1'b0;
      avg_done         <= 1'b0;
      triggered        <= 1'b0;
      r_rd_x           <= '0;
      r_rd_y           <= '0;
      r_rd_bx          <= '0;
      r_rd_sx          <= '0;
      r_rd_by          <= '0;
      r_rd_sy          <= '0;
      r_byte_idx       <= '0;
    end else begin
      r_key_prev <= KEY_2;
      uart_trmt  <= 1'b0;
      done       <= 1'b0;
      avg_done   <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_state          <= c_READ;
            start_resize     <= 1'b1;
            read_addr_resize <= '0;
            triggered        <= 1'b0;
            r_rd_x           <= '0;
            r_rd_y           <= '0;
            r_rd_bx          <= '0;
            r_rd_sx          <= '0;
            r_rd_by          <= '0;
            r_rd_sy          <= '0;
            r_byte_idx       <= '0;
          end
        end
        c_READ: begin
          if (start_resize) begin
            if (read_addr_resize == c_LAST_ADDR) begin
              start_resize <= 1'b0;
            end else begin
              read_addr_resize <= read_addr_resize + 23'd1;
              if (r_rd_sx == 5'd19) begin
                r_rd_sx <= '0;
                if (r_rd_bx == 5'd31) begin
                  r_rd_bx <= '0;
                  r_rd_x  <= '0;
                  r_rd_y  <= r_rd_y + 9'd1;
                  if (r_rd_sy == 4'd14) begin
                    r_rd_sy <= '0;
                    r_rd_by <= r_rd_by + 5'd1;
                  end else begin
                    r_rd_sy <= r_rd_sy + 4'd1;
                  end
                end else begin
                  r_rd_bx <= r_rd_bx + 5'd1;
                  r_rd_x  <= r_rd_x + 10'd1;
                end
              end else begin
                r_rd_sx <= r_rd_sx + 5'd1;
                r_rd_x  <= r_rd_x + 10'd1;
              end
            end
          end
          if (r_rows_done) begin
            r_state   <= c_SEND;
            avg_done  <= 1'b1;
            triggered <= 1'b1;
          end
        end
        c_SEND: begin
          if (tx_done) begin
            uart_tx   <= out[r_byte_idx[9:5]][r_byte_idx[4:0]];
            uart_trmt <= 1'b1;
            r_state   <= c_WAIT_TX;
          end
        end
        c_WAIT_TX: begin
          if (r_byte_idx == c_LAST_BYTE) begin
            done       <= 1'b1;
            r_byte_idx <= '0;
            r_state    <= c_IDLE;
          end else begin
            r_byte_idx <= r_byte_idx + 10'd1;
            r_state    <= c_SEND;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1        <= 1'b0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_bx1       <= '0;
      r_by1       <= '0;
      r_eob1      <= 1'b0;
      r_flush     <= 1'b0;
      r_flush_by  <= '0;
      r_rows_done <= 1'b0;
      for (int b = 0; b < 32; b++) r_acc[b] <= '0;
    end else begin
      r_v1        <= start_resize;
      r_x1        <= r_rd_x;
      r_y1        <= r_rd_y;
      r_bx1       <= r_rd_bx;
      r_by1       <= r_rd_by;
      r_eob1      <= (r_rd_x == 10'd639) && (r_rd_sy == 4'd14);
      r_flush     <= r_v1 && r_eob1;
      r_flush_by  <= r_by1;
      r_rows_done <= r_flush && (r_flush_by == 5'd31);
      // The first pixel of the next block row lands on the flush edge
      for (int b = 0; b < 32; b++) begin
        if (r_state == c_IDLE && w_start) begin
          r_acc[b] <= '0;
        end else if (r_flush) begin
          r_acc[b] <= (r_v1 && r_bx1 == 5'(b)) ? {9'd0, Read_DATA2} : 17'd0;
        end else if (r_v1 && r_bx1 == 5'(b)) begin
          r_acc[b] <= r_acc[b] + {9'd0, Read_DATA2};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && r_v1) begin
      receive[r_y1][r_x1] <= Read_DATA2;
    end
    if (rst_n && r_flush) begin
      for (int b = 0; b < 32; b++) out[r_flush_by][b] <= w_quot[b];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_resize_avg_simple.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_image_resize_avg_simple
// Bench for image_resize_avg_simple against a block-mean reference model.
// Revision : 1.0
// ============================================================================
module tb_image_resize_avg_simple;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        KEY_2;
  logic [7:0]  Read_DATA2;
  logic        tx_done;
  logic        start_resize;
  logic [22:0] read_addr_resize;
  logic        done;
  logic [7:0]  uart_tx;
  logic        uart_trmt;
  logic        avg_done;
  logic        triggered;

  always #5 clk = ~clk;

  image_resize_avg_simple dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .KEY_2            (KEY_2),
    .Read_DATA2       (Read_DATA2),
    .tx_done          (tx_done),
    .start_resize     (start_resize),
    .read_addr_resize (read_addr_resize),
    .done             (done),
    .uart_tx          (uart_tx),
    .uart_trmt        (uart_trmt),
    .avg_done         (avg_done),
    .triggered        (triggered)
  );

  logic [7:0]  mem [0:307199];
  int unsigned exp_thumb [0:1023];
  int unsigned sums [0:1023];
  int compared   = 0;
  int mismatched = 0;

  // Frame memory with one cycle of read latency
  always @(posedge clk)
    Read_DATA2 <= (read_addr_resize < 23'd307200) ? mem[read_addr_resize] : 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_start_resize"}, 32'(start_resize), 0);
    check({tag, "_read_addr"}, 32'(read_addr_resize), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_uart_tx"}, 32'(uart_tx), 0);
    check({tag, "_uart_trmt"}, 32'(uart_trmt), 0);
    check({tag, "_avg_done"}, 32'(avg_done), 0);
    check({tag, "_triggered"}, 32'(triggered), 0);
  endtask

  function automatic int paddr(input int by, input int bx, input int r, input int c);
    return (15 * by + r) * 640 + 20 * bx + c;
  endfunction

  initial begin
    int n;
    int addr_bad;
    int nbytes;
    int ndone;
    int post;
    int stall_bad;
    bit stalled;

    for (int i = 0; i < 307200; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 20; c++) begin
        mem[paddr(0, 0, r, c)] = 8'd255;
        mem[paddr(0, 1, r, c)] = 8'd0;
        mem[paddr(0, 2, r, c)] = 8'd0;
        mem[paddr(0, 3, r, c)] = 8'd0;
      end
    end
    mem[paddr(0, 2, 0, 0)]  = 8'd255;
    mem[paddr(0, 2, 14, 19)] = 8'd44;
    mem[paddr(0, 3, 7, 0)]  = 8'd255;
    mem[paddr(0, 3, 14, 19)] = 8'd45;

    for (int i = 0; i < 1024; i++) sums[i] = 0;
    for (int y = 0; y < 480; y++)
      for (int x = 0; x < 640; x++)
        sums[(y / 15) * 32 + (x / 20)] += int'(mem[y * 640 + x]);
    for (int i = 0; i < 1024; i++) exp_thumb[i] = sums[i] / 300;

    rst_n   = 1'b0;
    KEY_2   = 1'b1;
    tx_done = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_start", 32'(start_resize), 0);

    // Held low for several cycles: must start exactly once
    KEY_2 = 1'b0;
    @(negedge clk);
    n = 0;
    addr_bad = 0;
    while (start_resize === 1'b1 && n < 307300) begin
      if (read_addr_resize !== 23'(n)) addr_bad++;
      n++;
      if (n == 5) KEY_2 = 1'b1;
      @(negedge clk);
    end
    check("read_cycles", n, 307200);
    check("addr_sequence_errors", addr_bad, 0);

    repeat (3) @(negedge clk);
    check("avg_done_pulse", 32'(avg_done), 1);
    check("triggered_set", 32'(triggered), 1);
    check("blk255", 32'(dut.out[0][0]), 255);
    check("blk0", 32'(dut.out[0][1]), 0);
    check("blk_sum299", 32'(dut.out[0][2]), 0);
    check("blk_sum300", 32'(dut.out[0][3]), 1);
    for (int i = 0; i < 1024; i++)
      check($sformatf("thumb_%0d_%0d", i / 32, i % 32), 32'(dut.out[i / 32][i % 32]), exp_thumb[i]);
    check("recv_first", 32'(dut.receive[0][0]), 32'(mem[0]));
    check("recv_last", 32'(dut.receive[479][639]), 32'(mem[307199]));
    for (int k = 0; k < 4; k++) begin
      int y;
      int x;
      y = $urandom_range(0, 479);
      x = $urandom_range(0, 639);
      check($sformatf("recv_%0d_%0d", y, x), 32'(dut.receive[y][x]), 32'(mem[y * 640 + x]));
    end

    @(negedge clk);
    check("first_strobe", 32'(uart_trmt), 1);
    nbytes  = 0;
    ndone   = 0;
    post    = 0;
    stalled = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      if (uart_trmt === 1'b1) begin
        if (nbytes < 1024) check($sformatf("uart_byte%0d", nbytes), 32'(uart_tx), exp_thumb[nbytes]);
        nbytes++;
      end
      if (done === 1'b1) ndone++;
      if (ndone > 0) post++;
      if (post > 10) break;
      if (nbytes == 300 && !stalled) begin
        stalled   = 1'b1;
        tx_done   = 1'b0;
        stall_bad = 0;
        for (int s = 0; s < 50; s++) begin
          @(negedge clk);
          if (uart_trmt !== 1'b0 || uart_tx !== 8'(exp_thumb[299])) stall_bad++;
        end
        tx_done = 1'b1;
        check("stall_quiet", stall_bad, 0);
      end
      @(negedge clk);
    end
    check("uart_byte_count", nbytes, 1024);
    check("done_count", ndone, 1);
    check("idle_after_send", 32'(start_resize), 0);
    check("triggered_held", 32'(triggered), 1);

    // A new start clears triggered; a reset mid-READ aborts
    KEY_2 = 1'b0;
    @(negedge clk);
    KEY_2 = 1'b1;
    check("restart_start_resize", 32'(start_resize), 1);
    check("restart_triggered_clr", 32'(triggered), 0);
    check("restart_addr0", 32'(read_addr_resize), 0);
    repeat (999) @(negedge clk);
    check("restart_addr999", 32'(read_addr_resize), 999);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("midread_reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 32'(start_resize), 0);
    check("array_retained", 32'(dut.out[0][0]), 255);
    KEY_2 = 1'b0;
    @(negedge clk);
    KEY_2 = 1'b1;
    check("repress_start_resize", 32'(start_resize), 1);
    check("repress_addr0", 32'(read_addr_resize), 0);
    check("repress_triggered", 32'(triggered), 0);
    repeat (10) @(negedge clk);
    check("repress_addr10", 32'(read_addr_resize), 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_resize_avg_simple.md
# image_resize_avg_simple

Captures one 640×480 8-bit grayscale frame from frame memory after a button press and averages it down to a 32×32 thumbnail (each output pixel is the mean of a 20×15 block). It then streams the 1024 thumbnail bytes to a UART transmitter. It sits between the camera frame buffer (read port) and the UART TX block in the face-filter display path.

## Interface
- No parameters. Fixed geometry: width 640, height 480, block 20×15, output 32×32.
- clk  in  1  system clock; every register is clocked on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- KEY_2  in  1  active-low start button, sampled every clock.
- Read_DATA2  in  8  frame-memory read data. Valid one cycle after its address.
- tx_done  in  1  UART transmitter idle/done level (1 = ready for a byte).
- start_resize  out  1  high while frame-memory reads are being issued.
- read_addr_resize  out  23  frame-memory read address, raster order y*640+x.
- done  out  1  one-cycle pulse after the last UART byte is accepted.
- uart_tx  out  8  byte to transmit.
- uart_trmt  out  1  one-cycle transmit strobe.
- avg_done  out  1  one-cycle pulse when all 1024 averages are written.
- triggered  out  1  sticky "thumbnail valid" flag.

## Operation
- Internal storage, with names fixed for hierarchical checking:
  - receive[0:479][0:639], 8 bits each: the captured frame.
  - out[0:31][0:31], 8 bits each: the thumbnail. out[by][bx] is the block covering rows 15by..15by+14 and columns 20bx..20bx+19.
  - Neither array is reset.
- KEY_2 falling-edge detect: a registered previous value; start = !KEY_2 && key_prev. Presses outside IDLE are ignored.
- States:
  - IDLE → READ on start. In the same transition, clear triggered and the pixel counters.
  - READ: issue 307200 addresses 0..307199, one per cycle. Capture Read_DATA2 into receive[y][x] one cycle after each address.
  - Accumulate on the fly into 32 column accumulators acc[x/20], each 17 bits (max 300×255=76500).
  - After the capture of the pixel at x=639 on a row with y%15==14, on the next edge:
    - write out[by][bx] = floor(acc[bx]/300) for all bx. The division is exact integer floor, with no rounding.
    - clear all accumulators.
  - READ → SEND one edge after the final block row is written. On that edge pulse avg_done and set triggered.
  - SEND: if tx_done==1, drive uart_tx = next byte, pulse uart_trmt and go to WAIT_TX. Otherwise stay in SEND.
  - Byte order is out[0][0], out[0][1] … out[31][31], row-major.
  - WAIT_TX: one cycle, then back to SEND. After byte 1023, pulse done and go to IDLE instead.
- triggered stays high until reset or the next accepted start.

## Timing
- Reset (rst_n=0 at an edge): all outputs 0, state IDLE, key_prev=1, counters and accumulators 0.
- Reset mid-operation aborts immediately to IDLE. Array contents are retained.
- Let E0 be the edge that accepts start:
  - start_resize is high after E0 through the cycle that presents address 307199.
  - read_addr_resize = k during the cycle after edge E0+k.
  - Pixel k is sampled at edge E0+k+2. The last capture edge is Ec = E0+307201.
  - out row 31 is written at Ec+1.
  - avg_done pulses, triggered rises and SEND is entered at Ec+2.
- With tx_done held at 1, one byte is sent every 2 cycles:
  - uart_trmt is high in the cycles after edges Ec+3, Ec+5, …
  - done pulses in the cycle after the 1024th WAIT_TX edge.
- uart_tx holds its value until the next strobe. tx_done low stalls SEND indefinitely without losing bytes.
- A KEY_2 held low produces only one start.
- start_resize is 0 in IDLE, SEND and WAIT_TX.

## Test plan
- Reset → all outputs 0; KEY_2 high → stays IDLE, start_resize=0.
- One-cycle KEY_2 low pulse, then memory returns pixel_count%256 on each cycle start_resize is high:
  - start_resize is high for exactly 307200 cycles;
  - addresses run 0..307199;
  - triggered rises;
  - every out[by][bx] equals floor(Σ receive block/300) for all 1024 blocks.
- Constant 255 frame → all out = 255. Constant 0 → all 0. Block with sum 299 → 0, sum 300 → 1.
- tx_done=1 constant → 1024 uart_trmt pulses, each carrying out in row-major order, then done exactly once.
- tx_done held 0 for 50 cycles mid-stream → no uart_trmt during the stall; the next byte is correct after release.
- Reset asserted mid-READ → IDLE with outputs 0; a new KEY_2 press restarts from address 0 and triggered is cleared until completion.
